// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan engine: GROUPS banks of DIGITS digits share one digit-select bus.
// Double-buffered frame load, per-digit blink, per-bank leading-zero blanking, frame-gated brightness.
module seg_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int GROUPS       = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                       led_clk,
    input  logic                       rstn,
    input  logic                       load,
    input  logic [GROUPS*DIGITS*5-1:0] glyph_in,
    input  logic [GROUPS*DIGITS-1:0]   dp_in,
    input  logic [GROUPS*DIGITS-1:0]   blink_in,
    input  logic [GROUPS-1:0]          lz_en,
    input  logic [1:0]                 bright,
    output logic [GROUPS*7-1:0]        seg_out,
    output logic [GROUPS-1:0]          dp_out,
    output logic [DIGITS-1:0]          mux_out,
    output logic                       frame_tick,
    output logic                       pending
);
    localparam int N     = GROUPS * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DIGITS - 1);
    localparam logic [FC_W-1:0]   LAST_FRAME = FC_W'(BLINK_FRAMES - 1);
    localparam logic [N*5-1:0]    ALL_BLANK  = {N{5'd15}};
    localparam logic [DIGITS-1:0] MUX_FIRST  = DIGITS'(1);

    function automatic logic [6:0] decode_glyph(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'b1111110;
            5'd1:    seg = 7'b0110000;
            5'd2:    seg = 7'b1101101;
            5'd3:    seg = 7'b1111001;
            5'd4:    seg = 7'b0110011;
            5'd5:    seg = 7'b1011011;
            5'd6:    seg = 7'b1011111;
            5'd7:    seg = 7'b1110000;
            5'd8:    seg = 7'b1111111;
            5'd9:    seg = 7'b1111011;
            5'd10:   seg = 7'b1011011;
            5'd11:   seg = 7'b1001111;
            5'd12:   seg = 7'b0001110;
            5'd13:   seg = 7'b1001110;
            5'd14:   seg = 7'b0001111;
            5'd16:   seg = 7'b0000001;
            5'd17:   seg = 7'b1100111;
            5'd18:   seg = 7'b1011011;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    logic [IDX_W-1:0]    r_idx;
    logic [FC_W-1:0]     r_frame_cnt;
    logic                r_blink_ph;
    logic [1:0]          r_fph;
    logic [N*5-1:0]      r_act_glyph;
    logic [N-1:0]        r_act_dp;
    logic [N-1:0]        r_act_blink;
    logic [N*5-1:0]      r_pnd_glyph;
    logic [N-1:0]        r_pnd_dp;
    logic [N-1:0]        r_pnd_blink;
    logic                r_pending;
    logic [GROUPS*7-1:0] r_seg;
    logic [GROUPS-1:0]   r_dp;
    logic [DIGITS-1:0]   r_mux;
    logic                r_tick;

    logic                w_boundary;
    logic                w_lit;
    logic [N-1:0]        w_zrun;
    logic                w_run;
    logic                w_blank;
    logic [4:0]          w_code;
    logic [GROUPS*7-1:0] w_seg_nxt;
    logic [GROUPS-1:0]   w_dp_nxt;
    logic [DIGITS-1:0]   w_mux_nxt;

    assign w_boundary = (r_idx == LAST_IDX);

    // Digit slot counter plus the per-frame blink and brightness counters.
    always_ff @(posedge led_clk or negedge rstn) begin
        if (!rstn) begin
            r_idx       <= {IDX_W{1'b0}};
            r_frame_cnt <= {FC_W{1'b0}};
            r_blink_ph  <= 1'b0;
            r_fph       <= 2'd0;
        end else begin
            r_idx <= w_boundary ? {IDX_W{1'b0}} : r_idx + IDX_W'(1);
            if (w_boundary) begin
                r_fph <= r_fph + 2'd1;
                if (r_frame_cnt == LAST_FRAME) begin
                    r_frame_cnt <= {FC_W{1'b0}};
                    r_blink_ph  <= ~r_blink_ph;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FC_W'(1);
                end
            end
        end
    end

    // Double buffer: the active frame only changes at a frame boundary, so no tearing.
    always_ff @(posedge led_clk or negedge rstn) begin
        if (!rstn) begin
            r_act_glyph <= ALL_BLANK;
            r_act_dp    <= {N{1'b0}};
            r_act_blink <= {N{1'b0}};
            r_pnd_glyph <= ALL_BLANK;
            r_pnd_dp    <= {N{1'b0}};
            r_pnd_blink <= {N{1'b0}};
            r_pending   <= 1'b0;
        end else if (load && w_boundary) begin
            r_act_glyph <= glyph_in;
            r_act_dp    <= dp_in;
            r_act_blink <= blink_in;
            r_pending   <= 1'b0;
        end else if (load) begin
            r_pnd_glyph <= glyph_in;
            r_pnd_dp    <= dp_in;
            r_pnd_blink <= blink_in;
            r_pending   <= 1'b1;
        end else if (w_boundary && r_pending) begin
            r_act_glyph <= r_pnd_glyph;
            r_act_dp    <= r_pnd_dp;
            r_act_blink <= r_pnd_blink;
            r_pending   <= 1'b0;
        end else begin
            r_pending   <= r_pending;
        end
    end

    // Next-slot segment image; priority is unlit frame > blink-off > leading-zero blank > decode.
    always_comb begin
        w_lit     = (r_fph <= bright);
        w_mux_nxt = w_lit ? (MUX_FIRST << r_idx) : {DIGITS{1'b0}};
        w_seg_nxt = {(GROUPS*7){1'b0}};
        w_dp_nxt  = {GROUPS{1'b0}};
        w_zrun    = {N{1'b0}};
        w_run     = 1'b0;
        w_blank   = 1'b0;
        w_code    = 5'd0;
        for (int g = 0; g < GROUPS; g++) begin
            // w_zrun[k]: digit k and every digit above it are zero with no dp.
            w_run = 1'b1;
            for (int k = DIGITS - 1; k >= 0; k--) begin
                w_run = w_run & (r_act_glyph[(g*DIGITS + k)*5 +: 5] == 5'd0)
                              & ~r_act_dp[g*DIGITS + k];
                w_zrun[g*DIGITS + k] = w_run;
            end
            w_code  = r_act_glyph[(g*DIGITS + int'(r_idx))*5 +: 5];
            w_blank = (r_blink_ph & r_act_blink[g*DIGITS + int'(r_idx)])
                    | (lz_en[g] & (r_idx != {IDX_W{1'b0}}) & w_zrun[g*DIGITS + int'(r_idx)]);
            if (!w_lit || w_blank) begin
                w_seg_nxt[g*7 +: 7] = 7'b0000000;
                w_dp_nxt[g]         = 1'b0;
            end else begin
                w_seg_nxt[g*7 +: 7] = decode_glyph(w_code);
                w_dp_nxt[g]         = r_act_dp[g*DIGITS + int'(r_idx)];
            end
        end
    end

    // Output registers: select, segments and dp move together on one edge.
    always_ff @(posedge led_clk or negedge rstn) begin
        if (!rstn) begin
            r_mux  <= MUX_FIRST;
            r_seg  <= {(GROUPS*7){1'b0}};
            r_dp   <= {GROUPS{1'b0}};
            r_tick <= 1'b0;
        end else begin
            r_mux  <= w_mux_nxt;
            r_seg  <= w_seg_nxt;
            r_dp   <= w_dp_nxt;
            r_tick <= w_boundary;
        end
    end

    assign seg_out    = r_seg;
    assign dp_out     = r_dp;
    assign mux_out    = r_mux;
    assign frame_tick = r_tick;
    assign pending    = r_pending;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-level reference model pushes the expected
// output of every scan slot; a negedge monitor pops and compares.
module tb_seg_scan_ctrl;
    localparam int D  = 4;
    localparam int G  = 2;
    localparam int BF = 2;
    localparam int N  = D * G;

    logic             led_clk  = 1'b0;
    logic             rstn     = 1'b1;
    logic             load     = 1'b0;
    logic [N*5-1:0]   glyph_in = '0;
    logic [N-1:0]     dp_in    = '0;
    logic [N-1:0]     blink_in = '0;
    logic [G-1:0]     lz_en    = '0;
    logic [1:0]       bright   = 2'd3;
    logic [G*7-1:0]   seg_out;
    logic [G-1:0]     dp_out;
    logic [D-1:0]     mux_out;
    logic             frame_tick;
    logic             pending;

    seg_scan_ctrl #(.DIGITS(D), .GROUPS(G), .BLINK_FRAMES(BF)) dut (
        .led_clk(led_clk), .rstn(rstn), .load(load), .glyph_in(glyph_in),
        .dp_in(dp_in), .blink_in(blink_in), .lz_en(lz_en), .bright(bright),
        .seg_out(seg_out), .dp_out(dp_out), .mux_out(mux_out),
        .frame_tick(frame_tick), .pending(pending)
    );

    always #5 led_clk = ~led_clk;

    typedef struct packed {
        logic [G*7-1:0] seg;
        logic [G-1:0]   dp;
        logic [D-1:0]   mux;
        logic           tick;
        logic           pend;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_pop = 0;

    // Reference model state: slot in frame, frames since reset, buffers as plain arrays.
    int   m_slot, m_frame;
    int   a_gl[N], p_gl[N];
    bit   a_dp[N], p_dp[N], a_bl[N], p_bl[N];
    bit   m_pend;
    exp_t m_e;
    bit   m_lit, m_ph, m_lz, m_bnd;
    int   m_i;

    function automatic logic [6:0] seg_of(int c);
        case (c)
            0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
            3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
            6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
            9: return 7'b1111011;  10: return 7'b1011011; 11: return 7'b1001111;
            12: return 7'b0001110; 13: return 7'b1001110; 14: return 7'b0001111;
            16: return 7'b0000001; 17: return 7'b1100111; 18: return 7'b1011011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            a_gl[i] = 15; p_gl[i] = 15;
            a_dp[i] = 1'b0; p_dp[i] = 1'b0; a_bl[i] = 1'b0; p_bl[i] = 1'b0;
        end
        m_pend = 1'b0; m_slot = 0; m_frame = 0;
    endtask

    always @(posedge led_clk) begin
        if (!rstn) begin
            model_reset();
        end else begin
            m_lit = ((m_frame % 4) <= int'(bright));
            m_ph  = (((m_frame / BF) % 2) == 1);
            m_e   = '0;
            for (int g = 0; g < G; g++) begin
                m_i  = g*D + m_slot;
                m_lz = 1'b0;
                if (lz_en[g] && m_slot != 0) begin
                    m_lz = 1'b1;
                    for (int k = m_slot; k < D; k++)
                        if (a_gl[g*D+k] != 0 || a_dp[g*D+k]) m_lz = 1'b0;
                end
                if (m_lit && !(m_ph && a_bl[m_i]) && !m_lz) begin
                    m_e.seg[g*7 +: 7] = seg_of(a_gl[m_i]);
                    m_e.dp[g]         = a_dp[m_i];
                end
            end
            if (m_lit) m_e.mux[m_slot] = 1'b1;
            m_bnd     = (m_slot == D-1);
            m_e.tick  = m_bnd;
            if (load && m_bnd) begin
                for (int i = 0; i < N; i++) begin
                    a_gl[i] = int'(glyph_in[i*5 +: 5]); a_dp[i] = dp_in[i]; a_bl[i] = blink_in[i];
                end
                m_pend = 1'b0;
            end else if (load) begin
                for (int i = 0; i < N; i++) begin
                    p_gl[i] = int'(glyph_in[i*5 +: 5]); p_dp[i] = dp_in[i]; p_bl[i] = blink_in[i];
                end
                m_pend = 1'b1;
            end else if (m_bnd && m_pend) begin
                a_gl = p_gl; a_dp = p_dp; a_bl = p_bl;
                m_pend = 1'b0;
            end
            m_e.pend = m_pend;
            q.push_back(m_e);
            m_slot = (m_slot + 1) % D;
            if (m_bnd) m_frame++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp_v);
        end
    endtask

    exp_t mon_e;
    always @(negedge led_clk) begin
        if (rstn) begin
            if (q.size() == 0) begin
                chk("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                mon_e = q.pop_front();
                n_pop++;
                chk("seg_out", 32'(seg_out), 32'(mon_e.seg));
                chk("dp_out", 32'(dp_out), 32'(mon_e.dp));
                chk("mux_out", 32'(mux_out), 32'(mon_e.mux));
                chk("frame_tick", 32'(frame_tick), 32'(mon_e.tick));
                chk("pending", 32'(pending), 32'(mon_e.pend));
            end
        end
    end

    task automatic cyc();
        @(negedge led_clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_mux", 32'(mux_out), 32'd1);
        chk("rst_seg", 32'(seg_out), 32'd0);
        chk("rst_dp", 32'(dp_out), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge led_clk);
        #2;
        rstn = 1'b0;
        load = 1'b0;
        q.delete();
        #1;
        check_reset_outputs();
        repeat (2) @(posedge led_clk);
        @(negedge led_clk);
        #2;
        rstn = 1'b1;
    endtask

    task automatic set_glyphs(input int d3, input int d2, input int d1, input int d0,
                              input logic [D-1:0] dpm);
        for (int g = 0; g < G; g++) begin
            glyph_in[(g*D+0)*5 +: 5] = 5'(d0);
            glyph_in[(g*D+1)*5 +: 5] = 5'(d1);
            glyph_in[(g*D+2)*5 +: 5] = 5'(d2);
            glyph_in[(g*D+3)*5 +: 5] = 5'(d3);
            dp_in[g*D +: D] = dpm;
        end
    endtask

    task automatic load_at(input int slot);
        for (int t = 0; t < 2*D && m_slot != slot; t++) cyc();
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge led_clk);
        @(negedge led_clk);
        #2;
        rstn = 1'b1;

        bright = 2'd3;
        repeat (8) cyc();
        set_glyphs(3, 2, 1, 0, 4'b0000);
        load_at(1);
        repeat (8) cyc();
        set_glyphs(9, 8, 7, 6, 4'b0101);
        load_at(D-1);
        repeat (8) cyc();

        set_glyphs(8, 8, 8, 8, 4'b0000);
        blink_in = '0;
        for (int g = 0; g < G; g++) blink_in[g*D+1] = 1'b1;
        load_at(2);
        repeat (10*D) cyc();
        bright = 2'd0;
        repeat (8*D) cyc();
        bright = 2'd2;
        repeat (8*D) cyc();
        bright = 2'd3;

        blink_in = '0;
        lz_en = '1;
        set_glyphs(0, 0, 5, 0, 4'b0000);
        load_at(0);
        repeat (2*D) cyc();
        set_glyphs(0, 0, 0, 0, 4'b0000);
        load_at(1);
        repeat (2*D) cyc();
        set_glyphs(0, 0, 0, 0, 4'b1000);
        load_at(2);
        repeat (2*D) cyc();

        for (int c = 0; c < 2500; c++) begin
            cyc();
            if (c == 1200) do_reset();
            load = (($urandom % 6) == 0);
            for (int i = 0; i < N; i++)
                glyph_in[i*5 +: 5] = (($urandom % 2) == 0) ? 5'd0 : 5'($urandom % 32);
            dp_in    = N'($urandom & $urandom);
            blink_in = N'($urandom);
            lz_en    = G'($urandom);
            if (($urandom % 8) == 0) bright = 2'($urandom);
        end
        load = 1'b0;
        repeat (4) cyc();
        chk("scoreboard_drained", 32'(n_pop > 2000), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
